// File: rtl/axil_req_sched.sv
// Round-robin scheduler that serialises single-beat register requests from NUM_REQ requesters
// onto one AXI-Lite master port, with a bounded wait for B/R responses.
module axil_req_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  input  logic [NUM_REQ-1:0]                    req_write_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]                    rsp_ready_o,
  output logic                                  rsp_error_o,
  output logic [AXI_DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic [AXI_ADDR_WIDTH-1:0]             aw_addr_o,
  output logic [2:0]                            aw_prot_o,
  output logic                                  aw_valid_o,
  input  logic                                  aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]             w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]           w_strb_o,
  output logic                                  w_valid_o,
  input  logic                                  w_ready_i,
  input  logic [1:0]                            b_resp_i,
  input  logic                                  b_valid_i,
  output logic                                  b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0]             ar_addr_o,
  output logic [2:0]                            ar_prot_o,
  output logic                                  ar_valid_o,
  input  logic                                  ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]             r_data_i,
  input  logic [1:0]                            r_resp_i,
  input  logic                                  r_valid_i,
  output logic                                  r_ready_o,
  output logic                                  busy_o,
  output logic                                  timeout_o
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {
    StIdle, StWr, StWrResp, StRdAddr, StRdResp, StResp
  } state_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic [IdxW-1:0]           grant_q, grant_d;
  logic                      write_q, write_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]          wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      timeout_q, timeout_d;

  logic [IdxW-1:0]           arb_idx;
  logic                      arb_found;
  logic [CntW-1:0]           cnt_inc;
  logic                      tmo_hit;

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin : p_arb
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!arb_found && req_valid_i[IdxW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(cand);
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d   = arb_idx;
          ptr_d     = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          write_d   = req_write_i[arb_idx];
          addr_d    = req_addr_i[32'(arb_idx) * AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          wdata_d   = req_wdata_i[32'(arb_idx) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          wstrb_d   = req_wstrb_i[32'(arb_idx) * StrbW +: StrbW];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i[arb_idx] ? StWr : StRdAddr;
        end
      end
      StWr: begin
        // Valids are already low once done, so ready alone marks the handshake.
        aw_done_d = aw_done_q | aw_ready_i;
        w_done_d  = w_done_q | w_ready_i;
        if (aw_done_d && w_done_d) begin
          cnt_d   = '0;
          state_d = StWrResp;
        end
      end
      StRdAddr: begin
        if (ar_ready_i) begin
          cnt_d   = '0;
          state_d = StRdResp;
        end
      end
      StWrResp: begin
        if (b_valid_i) begin
          err_d   = (b_resp_i != 2'b00);
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) begin
            err_d     = 1'b1;
            rdata_d   = '0;
            timeout_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StRdResp: begin
        if (r_valid_i) begin
          err_d   = (r_resp_i != 2'b00);
          rdata_d = r_data_i;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) begin
            err_d     = 1'b1;
            rdata_d   = '0;
            timeout_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign aw_valid_o = (state_q == StWr) && !aw_done_q;
  assign w_valid_o  = (state_q == StWr) && !w_done_q;
  assign ar_valid_o = (state_q == StRdAddr);
  assign aw_addr_o  = aw_valid_o ? addr_q : '0;
  assign ar_addr_o  = ar_valid_o ? addr_q : '0;
  assign w_data_o   = w_valid_o ? wdata_q : '0;
  assign w_strb_o   = w_valid_o ? wstrb_q : '0;
  assign aw_prot_o  = 3'b000;
  assign ar_prot_o  = 3'b000;

  // Ready in IDLE too, so late responses after a timeout are drained.
  assign b_ready_o = (state_q == StIdle) || (state_q == StWrResp) || (state_q == StRdResp);
  assign r_ready_o = b_ready_o;

  always_comb begin
    rsp_ready_o = '0;
    if (state_q == StResp) rsp_ready_o[grant_q] = 1'b1;
  end

  assign rsp_error_o = (state_q == StResp) && err_q;
  assign rsp_rdata_o = (state_q == StResp) ? rdata_q : '0;
  assign busy_o      = (state_q != StIdle);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_axil_req_sched.sv
// Bench for axil_req_sched: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-phase reference model.
module tb_axil_req_sched;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid = '0, req_write = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*DW/8-1:0] req_wstrb = '0;
  logic [N-1:0]      rsp_ready;
  logic              rsp_error;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     aw_addr, ar_addr;
  logic [2:0]        aw_prot, ar_prot;
  logic              aw_valid, w_valid, ar_valid, b_ready, r_ready, busy, timeout;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_strb;
  logic              aw_ready = 0, w_ready = 0, ar_ready = 0, b_valid = 0, r_valid = 0;
  logic [1:0]        b_resp = 0, r_resp = 0;
  logic [DW-1:0]     r_data = 0;

  axil_req_sched #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_ready_o(rsp_ready), .rsp_error_o(rsp_error), .rsp_rdata_o(rsp_rdata),
    .aw_addr_o(aw_addr), .aw_prot_o(aw_prot), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .ar_addr_o(ar_addr), .ar_prot_o(ar_prot), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready),
    .busy_o(busy), .timeout_o(timeout)
  );

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction in flight, tracked as idle / address / wait / done.
  typedef enum int {MIdle, MAddr, MWait, MDone} mph_e;
  mph_e          m_ph = MIdle;
  int            m_ptr = 0, m_idx = 0, m_wait = 0, m_done_cnt = 0, m_tmo_cnt = 0;
  bit            m_wr = 0, m_aw_hs = 0, m_w_hs = 0, m_err = 0, m_tmo = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0, m_rdata = 0;
  logic [3:0]    m_strb = 0;
  bit            e_aw_valid, e_w_valid, e_ar_valid;

  task automatic model_step();
    if (!rst_n) begin
      m_ph = MIdle; m_ptr = 0; m_tmo = 0;
    end else begin
      case (m_ph)
        MIdle: if (|req_valid) begin
          for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
          m_ptr   = (m_idx + 1) % N;
          m_wr    = req_write[m_idx];
          m_addr  = req_addr[m_idx*AW +: AW];
          m_wdata = req_wdata[m_idx*DW +: DW];
          m_strb  = req_wstrb[m_idx*4 +: 4];
          m_aw_hs = 0; m_w_hs = 0;
          m_ph    = MAddr;
        end
        MAddr: begin
          if (m_wr) begin
            if (e_aw_valid && aw_ready) m_aw_hs = 1;
            if (e_w_valid && w_ready) m_w_hs = 1;
            if (m_aw_hs && m_w_hs) begin m_ph = MWait; m_wait = 0; end
          end else if (e_ar_valid && ar_ready) begin
            m_ph = MWait; m_wait = 0;
          end
        end
        MWait: begin
          if (m_wr ? b_valid : r_valid) begin
            m_err   = ((m_wr ? b_resp : r_resp) != 2'b00);
            m_rdata = m_wr ? '0 : r_data;
            m_ph    = MDone;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin
              m_err = 1; m_rdata = '0; m_tmo = 1; m_tmo_cnt++; m_ph = MDone;
            end
          end
        end
        MDone: begin m_ph = MIdle; m_done_cnt++; end
        default: m_ph = MIdle;
      endcase
    end
    e_aw_valid = (m_ph == MAddr) && m_wr && !m_aw_hs;
    e_w_valid  = (m_ph == MAddr) && m_wr && !m_w_hs;
    e_ar_valid = (m_ph == MAddr) && !m_wr;
  endtask

  always @(posedge clk) begin
    logic [N-1:0] e_rsp;
    bit           e_rdy;
    #1;
    model_step();
    cyc++;
    e_rsp = '0;
    if (m_ph == MDone) e_rsp[m_idx] = 1'b1;
    e_rdy = (m_ph == MIdle) || (m_ph == MWait);
    chk("ctrl", {busy, aw_valid, w_valid, ar_valid, b_ready, r_ready, timeout},
        {m_ph != MIdle, e_aw_valid, e_w_valid, e_ar_valid, e_rdy, e_rdy, m_tmo});
    chk("aw", {aw_prot, aw_addr}, {3'b000, e_aw_valid ? m_addr : 32'h0});
    chk("w", {w_strb, w_data}, e_w_valid ? {m_strb, m_wdata} : 36'h0);
    chk("ar", {ar_prot, ar_addr}, {3'b000, e_ar_valid ? m_addr : 32'h0});
    chk("rsp", {rsp_ready, rsp_error, rsp_rdata},
        {e_rsp, (m_ph == MDone) && m_err, (m_ph == MDone) ? m_rdata : 32'h0});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*4 +: 4] = s;
  endtask

  initial begin
    int got[5];
    int exp_order[5];
    int n;
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_bready", {b_ready, r_ready}, 2'b11);
    chk("reset_rsp", rsp_ready, 0);
    chk("reset_timeout", timeout, 0);
    rst_n = 1;
    tick();

    // Single write, slave always ready.
    aw_ready = 1; w_ready = 1; ar_ready = 1; b_valid = 1; b_resp = 0;
    set_req(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF);
    tick();
    chk("t1_awvalid", {aw_valid, w_valid}, 2'b11);
    chk("t1_awaddr", aw_addr, 32'h1000);
    chk("t1_wdata", w_data, 32'hDEADBEEF);
    tick();
    chk("t1_norsp_c2", rsp_ready, 0);
    tick();
    chk("t1_rsp", rsp_ready, 4'b0001);
    chk("t1_err", rsp_error, 0);
    req_valid[0] = 0;
    tick();
    chk("t1_idle", busy, 0);

    // Single read with SLVERR.
    b_valid = 0; r_valid = 1; r_data = 32'hCAFEF00D; r_resp = 2'b10;
    set_req(2, 0, 32'h20, 32'h0, 4'h0);
    tick();
    chk("t2_arvalid", ar_valid, 1);
    chk("t2_araddr", ar_addr, 32'h20);
    tick();
    tick();
    chk("t2_rsp", rsp_ready, 4'b0100);
    chk("t2_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("t2_err", rsp_error, 1);
    req_valid[2] = 0;
    tick();

    // Round robin with all requesters continuously valid.
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
    r_resp = 0;
    for (int i = 0; i < N; i++) set_req(i, 0, 32'h100 + 32'(i) * 4, 32'h0, 4'h0);
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (|rsp_ready) begin
        for (int b = 0; b < N; b++) if (rsp_ready[b]) got[n] = b;
        n++;
      end
    end
    req_valid = '0;
    chk("t3_count", n, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_grant%0d", k), got[k], exp_order[k]);
    tick(); tick();

    // AW accepted three cycles before W.
    aw_ready = 1; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
    set_req(1, 1, 32'h44, 32'h12345678, 4'h3);
    tick();
    chk("t4_c1", {aw_valid, w_valid}, 2'b11);
    tick();
    chk("t4_c2", {aw_valid, w_valid}, 2'b01);
    chk("t4_awaddr_zero", aw_addr, 0);
    tick();
    chk("t4_c3", {aw_valid, w_valid}, 2'b01);
    tick();
    chk("t4_c4", {aw_valid, w_valid}, 2'b01);
    w_ready = 1; aw_ready = 0;
    tick();
    chk("t4_c5", {aw_valid, w_valid, busy, b_ready}, 4'b0011);
    w_ready = 0; b_valid = 1; b_resp = 0;
    tick();
    chk("t4_rsp", {rsp_ready, rsp_error}, {4'b0010, 1'b0});
    req_valid[1] = 0; b_valid = 0;
    tick();
    chk("t4_idle", busy, 0);

    // Response timeout, then a late B in idle.
    aw_ready = 1; w_ready = 1;
    set_req(3, 1, 32'h80, 32'h55, 4'h1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("t5_wait%0d", c), rsp_ready, 0);
    end
    tick();
    chk("t5_rsp", {rsp_ready, rsp_error, timeout}, {4'b1000, 1'b1, 1'b1});
    chk("t5_rdata", rsp_rdata, 0);
    req_valid[3] = 0;
    tick();
    b_valid = 1; b_resp = 0;
    tick();
    chk("t5_late", {rsp_ready, busy}, 5'b0);
    b_valid = 0;
    tick();
    chk("t5_sticky", {rsp_ready, timeout}, 5'b00001);

    // Reset while waiting for B.
    set_req(0, 1, 32'h8, 32'h9, 4'hF);
    tick();
    tick();
    chk("t6_busy", busy, 1);
    rst_n = 0; req_valid = '0;
    tick();
    chk("t6_reset", {busy, b_ready, timeout, aw_valid, w_valid, rsp_ready}, 9'b010000000);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_norsp", rsp_ready, 0);
    end

    // Randomized traffic.
    m_done_cnt = 0; m_tmo_cnt = 0;
    for (int c = 0; c < 4000 && bad < 200; c++) begin
      tick();
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) begin
        if (!rst_n || (m_ph == MDone && m_idx == i)) req_valid[i] = 0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      aw_ready = ($urandom_range(0, 2) != 0);
      w_ready  = ($urandom_range(0, 2) != 0);
      ar_ready = ($urandom_range(0, 2) != 0);
      b_valid  = ($urandom_range(0, 5) == 0);
      b_resp   = 2'($urandom_range(0, 3));
      r_valid  = ($urandom_range(0, 5) == 0);
      r_resp   = 2'($urandom_range(0, 3));
      r_data   = $urandom;
    end
    chk("rand_progress", m_done_cnt > 100, 1);
    chk("rand_timeouts", m_tmo_cnt > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
